fetch_queue: RTL and testbench

- Instruction fetch buffer between `branch_pred` / L1I and decode.
- Each cycle it accepts one fetch bundle: up to SUPER_SCALAR_WIDTH instruction words, the PC of the first lane, and per-lane `uop_branch` data.
- It stores these per instruction in a circular buffer.
- It presents up to SUPER_SCALAR_WIDTH oldest instructions per cycle to decode under a valid-count/ready handshake.
- On a redirect (`pc_correction`) the whole queue is flushed.

---
 rtl/fetch_queue_pkg.sv | 36 +++
 rtl/fetch_queue_if.sv | 44 ++++
 rtl/fetch_queue_storage.sv | 48 ++++
 rtl/fetch_queue.sv | 134 +++++++++++++
 tb/tb_fetch_queue.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Lane count, instruction width and default depth live here so the queue,
// its storage and its interface all agree on one set of widths.
package fetch_queue_pkg;

  localparam int SUPER_SCALAR_WIDTH = 4;
  localparam int INSTRUCTION_WIDTH  = 32;
  localparam int PC_WIDTH           = 64;
  localparam int FETCH_QUEUE_DEPTH  = 16;

  // Wide enough to hold 0..SUPER_SCALAR_WIDTH lanes.
  localparam int LANE_CNT_W = $clog2(SUPER_SCALAR_WIDTH + 1);

  typedef logic [LANE_CNT_W-1:0]        lane_cnt_t;
  typedef logic [INSTRUCTION_WIDTH-1:0] instr_t;
  typedef logic [PC_WIDTH-1:0]          pc_t;

  // Branch prediction payload carried alongside each fetched instruction.
  typedef struct packed {
    logic taken;
    pc_t  target;
  } uop_branch;

  // One queue slot: a single instruction with its own PC and prediction.
  typedef struct packed {
    instr_t    instr;
    pc_t       pc;
    uop_branch branch;
  } fetch_entry_t;

  // PC of a lane inside a fetch bundle: sequential 4-byte words, 64-bit wrap.
  function automatic pc_t lane_pc(pc_t base, int unsigned lane);
    return base + (pc_t'(lane) << 2);
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode bundle interface: enqueue side from branch_pred / L1I,
// dequeue side towards decode, plus flush and occupancy.
// master = surrounding pipeline, slave = fetch_queue.
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCH_QUEUE_DEPTH
);

  // Enqueue side
  logic                                             enq_valid_in;
  lane_cnt_t                                        enq_count_in;
  pc_t                                              enq_pc_in;
  logic [SUPER_SCALAR_WIDTH-1:0][INSTRUCTION_WIDTH-1:0] enq_instr_in;
  uop_branch [SUPER_SCALAR_WIDTH-1:0]               enq_branch_in;
  logic                                             enq_ready_out;

  // Redirect
  logic                                             flush_in;

  // Dequeue side
  logic                                             deq_ready_in;
  lane_cnt_t                                        deq_count_out;
  logic [SUPER_SCALAR_WIDTH-1:0][INSTRUCTION_WIDTH-1:0] deq_instr_out;
  logic [SUPER_SCALAR_WIDTH-1:0][PC_WIDTH-1:0]      deq_pc_out;
  uop_branch [SUPER_SCALAR_WIDTH-1:0]               deq_branch_out;

  logic [$clog2(DEPTH+1)-1:0]                       occupancy_out;

  modport master (
    output enq_valid_in, enq_count_in, enq_pc_in, enq_instr_in, enq_branch_in,
    output flush_in, deq_ready_in,
    input  enq_ready_out, deq_count_out, deq_instr_out, deq_pc_out,
    input  deq_branch_out, occupancy_out
  );

  modport slave (
    input  enq_valid_in, enq_count_in, enq_pc_in, enq_instr_in, enq_branch_in,
    input  flush_in, deq_ready_in,
    output enq_ready_out, deq_count_out, deq_instr_out, deq_pc_out,
    output deq_branch_out, occupancy_out
  );

endinterface

// File: rtl/fetch_queue_storage.sv
// Circular entry array for the fetch queue: SUPER_SCALAR_WIDTH write ports
// at consecutive (wrapping) indices from a base, and SUPER_SCALAR_WIDTH
// combinational read ports at consecutive indices from another base.
// Pointer and occupancy bookkeeping is the caller's job.
module fetch_queue_storage
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCH_QUEUE_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                                 clk_in,
  input  logic [SUPER_SCALAR_WIDTH-1:0]        i_wr_en,
  input  logic [PTR_W-1:0]                     i_wr_base,
  input  fetch_entry_t [SUPER_SCALAR_WIDTH-1:0] i_wr_data,
  input  logic [PTR_W-1:0]                     i_rd_base,
  output fetch_entry_t [SUPER_SCALAR_WIDTH-1:0] o_rd_data
);

  fetch_entry_t r_mem [DEPTH];

  logic [PTR_W-1:0] w_wr_idx [SUPER_SCALAR_WIDTH];
  logic [PTR_W-1:0] w_rd_idx [SUPER_SCALAR_WIDTH];

  // Per-lane slot indices; PTR_W-bit addition wraps at DEPTH.
  always_comb begin
    for (int i = 0; i < SUPER_SCALAR_WIDTH; i++) begin
      w_wr_idx[i] = i_wr_base + PTR_W'(i);
      w_rd_idx[i] = i_rd_base + PTR_W'(i);
    end
  end

  // Write the enabled lanes of the incoming bundle.
  // NOTE: the array has no reset; stale slots are never visible because the
  // caller masks every lane beyond the live occupancy.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < SUPER_SCALAR_WIDTH; i++) begin
      if (i_wr_en[i]) r_mem[w_wr_idx[i]] <= i_wr_data[i];
    end
  end

  // Present the oldest lanes starting at the read base.
  always_comb begin
    for (int j = 0; j < SUPER_SCALAR_WIDTH; j++) begin
      o_rd_data[j] = r_mem[w_rd_idx[j]];
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between branch_pred / L1I and decode.
// Accepts one bundle of up to SUPER_SCALAR_WIDTH instructions per cycle,
// stores one instruction per slot, and offers the oldest SUPER_SCALAR_WIDTH
// to decode with an all-or-nothing pop. A flush empties the queue.
// Optional build macro FETCH_QUEUE_BYPASS_EN: when the queue is empty the
// incoming bundle is shown on the dequeue outputs in the same cycle, and is
// not stored at all if decode takes it.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCH_QUEUE_DEPTH  // power of two, >= 2*SUPER_SCALAR_WIDTH
) (
  input  logic         clk_in,
  input  logic         rst_N_in,
  fetch_queue_if.slave bus
);

  localparam int        PTR_W     = $clog2(DEPTH);
  localparam int        OCC_W     = $clog2(DEPTH + 1);
  localparam lane_cnt_t LANES     = lane_cnt_t'(SUPER_SCALAR_WIDTH);
  // A full bundle fits while occupancy is at most this value.
  localparam logic [OCC_W-1:0] OCC_LIMIT = OCC_W'(DEPTH - SUPER_SCALAR_WIDTH);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [OCC_W-1:0] r_occ;

  logic      w_enq_ready;
  lane_cnt_t w_avail;      // lanes available from storage
  lane_cnt_t w_enq_n;      // lanes accepted this cycle
  lane_cnt_t w_wr_n;       // lanes actually written to storage
  lane_cnt_t w_pop_n;      // lanes popped from storage
  lane_cnt_t w_deq_count;
  logic      w_bypass;

  logic [SUPER_SCALAR_WIDTH-1:0]        w_wr_en;
  fetch_entry_t [SUPER_SCALAR_WIDTH-1:0] w_in_entry;
  fetch_entry_t [SUPER_SCALAR_WIDTH-1:0] w_rd_entry;
  fetch_entry_t [SUPER_SCALAR_WIDTH-1:0] w_out_entry;

  // Flow control and lane counts, all derived from registered occupancy.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the block can leave one unassigned and infer a latch.
    w_enq_ready = (r_occ <= OCC_LIMIT);
    w_avail     = (r_occ >= OCC_W'(SUPER_SCALAR_WIDTH)) ? LANES : lane_cnt_t'(r_occ);
    w_enq_n     = '0;
    w_bypass    = 1'b0;

    // Oversized counts are clamped so occupancy can never overrun DEPTH.
    if (bus.enq_valid_in && w_enq_ready && !bus.flush_in) begin
      w_enq_n = (bus.enq_count_in > LANES) ? LANES : bus.enq_count_in;
    end

`ifdef FETCH_QUEUE_BYPASS_EN
    w_bypass = (r_occ == '0) && (w_enq_n != '0);
`endif

    w_pop_n     = (bus.deq_ready_in && !bus.flush_in) ? w_avail : '0;
    // A bypassed bundle that decode consumes never touches storage.
    w_wr_n      = (w_bypass && bus.deq_ready_in) ? '0 : w_enq_n;
    w_deq_count = bus.flush_in ? '0 : (w_bypass ? w_enq_n : w_avail);
  end

  // Expand the incoming bundle into per-slot entries and lane write enables.
  always_comb begin
    for (int i = 0; i < SUPER_SCALAR_WIDTH; i++) begin
      w_in_entry[i].instr  = bus.enq_instr_in[i];
      w_in_entry[i].pc     = lane_pc(bus.enq_pc_in, i);
      w_in_entry[i].branch = bus.enq_branch_in[i];
      w_wr_en[i]           = (lane_cnt_t'(i) < w_wr_n);
    end
  end

  fetch_queue_storage #(
    .DEPTH(DEPTH)
  ) u_storage (
    .clk_in   (clk_in),
    .i_wr_en  (w_wr_en),
    .i_wr_base(r_tail),
    .i_wr_data(w_in_entry),
    .i_rd_base(r_head),
    .o_rd_data(w_rd_entry)
  );

  // Select bypass or stored lanes and zero every lane past the live count.
  always_comb begin
    for (int j = 0; j < SUPER_SCALAR_WIDTH; j++) begin
      w_out_entry[j] = '0;
      if (lane_cnt_t'(j) < w_deq_count) begin
        w_out_entry[j] = w_bypass ? w_in_entry[j] : w_rd_entry[j];
      end
      bus.deq_instr_out[j]  = w_out_entry[j].instr;
      bus.deq_pc_out[j]     = w_out_entry[j].pc;
      bus.deq_branch_out[j] = w_out_entry[j].branch;
    end
  end

  assign bus.enq_ready_out = w_enq_ready;
  assign bus.deq_count_out = w_deq_count;
  assign bus.occupancy_out = r_occ;

  // Head, tail and occupancy; a flush returns all three to zero.
  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else if (bus.flush_in) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      r_head <= r_head + PTR_W'(w_pop_n);
      r_tail <= r_tail + PTR_W'(w_wr_n);
      r_occ  <= r_occ + OCC_W'(w_wr_n) - OCC_W'(w_pop_n);
    end
  end

  // Upstream must never present more lanes than the bundle holds.
  a_enq_count_legal: assert property (
    @(posedge clk_in) disable iff (!rst_N_in)
    bus.enq_valid_in |-> (bus.enq_count_in <= LANES)
  );

  // Upstream must hold its bundle while there is no room; otherwise it is lost.
  a_enq_no_overrun: assert property (
    @(posedge clk_in) disable iff (!rst_N_in)
    (bus.enq_valid_in && !bus.flush_in) |-> bus.enq_ready_out
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized
// traffic, all compared by a scoreboard monitor against a queue model.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = FETCH_QUEUE_DEPTH;
  localparam int SSW   = SUPER_SCALAR_WIDTH;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk_in = 1'b0;
  logic rst_N_in;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk_in  (clk_in),
    .rst_N_in(rst_N_in),
    .bus     (bus)
  );

  always #5 clk_in = ~clk_in;

  // Scoreboard entry: expected instruction plus when it was enqueued.
  typedef struct {
    fetch_entry_t ent;
    int           enq_cycle;
    bit           byp;
  } sb_t;

  sb_t exp_q[$];
  int  cyc = 0;
  int  n_vec = 0;
  int  n_err = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of stimulus just after the clock edge and record what the
  // queue is expected to hold.
  task automatic drive(input bit valid, input int cnt, input logic [63:0] pc,
                       input bit rdy, input bit fl);
    int occ;
    bit room;
    bit v;
    fetch_entry_t e;
    @(posedge clk_in);
    #1;
    occ  = exp_q.size();
    room = (DEPTH - occ) >= SSW;
    v    = valid && room;
    bus.enq_valid_in = v;
    bus.enq_count_in = lane_cnt_t'(cnt);
    bus.enq_pc_in    = pc;
    bus.deq_ready_in = rdy;
    bus.flush_in     = fl;
    for (int i = 0; i < SSW; i++) begin
      bus.enq_instr_in[i]         = $urandom;
      bus.enq_branch_in[i].taken  = 1'($urandom);
      bus.enq_branch_in[i].target = {$urandom, $urandom};
    end
    if (v && !fl) begin
      for (int i = 0; i < cnt; i++) begin
        e.instr  = bus.enq_instr_in[i];
        e.pc     = pc + 64'(4 * i);
        e.branch = bus.enq_branch_in[i];
        exp_q.push_back('{ent: e, enq_cycle: cyc, byp: (BYP && occ == 0)});
      end
    end
  endtask

  task automatic idle(input bit rdy);
    drive(1'b0, 0, 64'h0, rdy, 1'b0);
  endtask

  // Monitor: mid-cycle, compare everything the DUT presents against the model.
  always @(negedge clk_in) begin
    int occ;
    int vis;
    int exp_cnt;
    fetch_entry_t ev;
    if (rst_N_in) begin
      occ = 0;
      vis = 0;
      foreach (exp_q[k]) if (exp_q[k].enq_cycle < cyc) occ++;
      for (int k = 0; k < exp_q.size(); k++) begin
        if (exp_q[k].enq_cycle < cyc || exp_q[k].byp) vis++;
        else break;
      end
      exp_cnt = bus.flush_in ? 0 : ((vis < SSW) ? vis : SSW);
      check("occupancy", bus.occupancy_out, occ);
      check("enq_ready", bus.enq_ready_out, (DEPTH - occ) >= SSW);
      check("deq_count", bus.deq_count_out, exp_cnt);
      for (int j = 0; j < SSW; j++) begin
        ev = (j < exp_cnt) ? exp_q[j].ent : '0;
        check($sformatf("deq_lane%0d", j),
              {bus.deq_instr_out[j], bus.deq_pc_out[j], bus.deq_branch_out[j]}, ev);
      end
      if (bus.flush_in) exp_q.delete();
      else if (bus.deq_ready_in) for (int j = 0; j < exp_cnt; j++) void'(exp_q.pop_front());
    end
  end

  task automatic check_reset_outputs();
    check("rst_occupancy", bus.occupancy_out, 0);
    check("rst_deq_count", bus.deq_count_out, 0);
    check("rst_enq_ready", bus.enq_ready_out, 1);
    check("rst_deq_pc", bus.deq_pc_out, 0);
    check("rst_deq_instr", bus.deq_instr_out, 0);
  endtask

  initial begin
    logic [63:0] pc;
    int          cnt;

    rst_N_in          = 1'b0;
    bus.enq_valid_in  = 1'b0;
    bus.enq_count_in  = '0;
    bus.enq_pc_in     = '0;
    bus.enq_instr_in  = '0;
    bus.enq_branch_in = '0;
    bus.deq_ready_in  = 1'b0;
    bus.flush_in      = 1'b0;
    #2;
    check_reset_outputs();
    #5 rst_N_in = 1'b1;

    // Basic enqueue: 3 lanes at 0x1000, visible the next cycle.
    drive(1'b1, 3, 64'h1000, 1'b0, 1'b0);
    idle(1'b1);
    @(negedge clk_in);
    check("basic_count", bus.deq_count_out, 3);
    check("basic_pc0", bus.deq_pc_out[0], 64'h1000);
    check("basic_pc1", bus.deq_pc_out[1], 64'h1004);
    check("basic_pc2", bus.deq_pc_out[2], 64'h1008);
    check("basic_lane3", bus.deq_pc_out[3], 0);
    idle(1'b0);
    @(negedge clk_in);
    check("basic_drained", bus.occupancy_out, 0);

    // Fill to 16 with decode stalled.
    pc = 64'h2000;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4, pc, 1'b0, 1'b0);
      pc += 16;
    end
    @(negedge clk_in);
    check("fill_occ12", bus.occupancy_out, 12);
    check("fill_ready12", bus.enq_ready_out, 1);
    idle(1'b0);
    @(negedge clk_in);
    check("fill_occ16", bus.occupancy_out, 16);
    check("fill_ready16", bus.enq_ready_out, 0);
    for (int i = 0; i < 4; i++) idle(1'b1);
    idle(1'b0);
    @(negedge clk_in);
    check("fill_empty", bus.occupancy_out, 0);

    // 4,4,4,1 leaves 13 entries: no room for a full bundle.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i == 3) ? 1 : 4, pc, 1'b0, 1'b0);
      pc += 16;
    end
    idle(1'b0);
    @(negedge clk_in);
    check("fill_occ13", bus.occupancy_out, 13);
    check("fill_ready13", bus.enq_ready_out, 0);

    // Pop 4 to reach 9, then flush while enqueuing and dequeuing.
    idle(1'b1);
    drive(1'b1, 4, 64'hDEAD_0000, 1'b1, 1'b1);
    @(negedge clk_in);
    check("flush_deq_count", bus.deq_count_out, 0);
    idle(1'b1);
    @(negedge clk_in);
    check("flush_occ", bus.occupancy_out, 0);
    check("flush_bundle_gone", bus.deq_count_out, 0);

    // Wrap-around: 4 in, 4 out per cycle across the 15->0 slot boundary.
    pc = 64'h4000;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 4, pc, 1'b1, 1'b0);
      pc += 16;
    end
    idle(1'b1);
    idle(1'b1);

    // Bypass (or not) on an empty queue.
    drive(1'b1, 2, 64'h8000, 1'b1, 1'b0);
    @(negedge clk_in);
    check("byp_same_cycle", bus.deq_count_out, BYP ? 2 : 0);
    check("byp_occ", bus.occupancy_out, 0);
    idle(1'b1);
    @(negedge clk_in);
    check("byp_next_cycle", bus.deq_count_out, BYP ? 0 : 2);
    idle(1'b1);

    // Reset mid-traffic with 7 entries held.
    drive(1'b1, 4, 64'hA000, 1'b0, 1'b0);
    drive(1'b1, 3, 64'hA010, 1'b0, 1'b0);
    idle(1'b1);
    check("pre_reset_occ", bus.occupancy_out, 7);
    #1 rst_N_in = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    @(negedge clk_in);
    #2 rst_N_in = 1'b1;

    // Randomized traffic, including occasional flushes and 64-bit PC wrap.
    pc = 64'h1_0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 30) == 0) pc = 64'hFFFF_FFFF_FFFF_FFF8;
      cnt = $urandom_range(0, SSW);
      drive($urandom_range(0, 3) != 0, cnt, pc, $urandom_range(0, 2) != 0,
            $urandom_range(0, 24) == 0);
      pc += 64'(4 * cnt);
    end
    for (int i = 0; i < 6; i++) idle(1'b1);
    @(negedge clk_in);
    check("final_empty", bus.occupancy_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
